// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM encoding, flag indices and overflow helpers for alu_seq
package alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_NOT   = 4'd5;
    localparam logic [3:0] OP_NAND  = 4'd6;
    localparam logic [3:0] OP_NOR   = 4'd7;
    localparam logic [3:0] OP_SHL   = 4'd8;
    localparam logic [3:0] OP_SHR   = 4'd9;
    localparam logic [3:0] OP_ASR   = 4'd10;
    localparam logic [3:0] OP_INC   = 4'd11;
    localparam logic [3:0] OP_DEC   = 4'd12;
    localparam logic [3:0] OP_PASSB = 4'd13;
    localparam logic [3:0] OP_MUL   = 4'd14;
    localparam logic [3:0] OP_CMP   = 4'd15;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_MUL_RUN = 1'b1;

    // flags = {C,V,N,Z}
    localparam int FLG_Z = 0;
    localparam int FLG_N = 1;
    localparam int FLG_V = 2;
    localparam int FLG_C = 3;

    // Signed overflow on addition: operands agree in sign, result does not.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

    // Signed overflow on subtraction: operands differ in sign, result sign flips from A.
    function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb != b_msb) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational single-cycle ALU operations (all opcodes except MUL)
import alu_pkg::*;

module alu_core #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic [3:0]       F,
    output logic [WIDTH-1:0] D,
    output logic [3:0]       flags
);

    // Arithmetic is done one bit wider so the top bit is the carry/borrow.
    logic [WIDTH:0] add_r;
    logic [WIDTH:0] sub_r;
    logic [WIDTH:0] inc_r;
    logic [WIDTH:0] dec_r;
    logic [WIDTH:0] cmp_r;

    assign add_r = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Cin};
    assign sub_r = {1'b0, A} - {1'b0, B} - {{WIDTH{1'b0}}, Cin};
    assign inc_r = {1'b0, A} + {{WIDTH{1'b0}}, 1'b1};
    assign dec_r = {1'b0, A} - {{WIDTH{1'b0}}, 1'b1};
    assign cmp_r = {1'b0, A} - {1'b0, B};

    logic             c;
    logic             v;
    logic [WIDTH-1:0] nz_src;

    // Opcode decode; CMP reports N/Z of the difference while passing A through.
    always_comb begin
        D      = '0;
        c      = 1'b0;
        v      = 1'b0;
        case (F)
            OP_ADD: begin
                D = add_r[WIDTH-1:0];
                c = add_r[WIDTH];
                v = add_ovf(A[WIDTH-1], B[WIDTH-1], add_r[WIDTH-1]);
            end
            OP_SUB: begin
                D = sub_r[WIDTH-1:0];
                c = sub_r[WIDTH];
                v = sub_ovf(A[WIDTH-1], B[WIDTH-1], sub_r[WIDTH-1]);
            end
            OP_AND:   D = A & B;
            OP_OR:    D = A | B;
            OP_XOR:   D = A ^ B;
            OP_NOT:   D = ~A;
            OP_NAND:  D = ~(A & B);
            OP_NOR:   D = ~(A | B);
            OP_SHL: begin
                D = {A[WIDTH-2:0], Cin};
                c = A[WIDTH-1];
            end
            OP_SHR: begin
                D = {1'b0, A[WIDTH-1:1]};
                c = A[0];
            end
            OP_ASR: begin
                D = {A[WIDTH-1], A[WIDTH-1:1]};
                c = A[0];
            end
            OP_INC: begin
                D = inc_r[WIDTH-1:0];
                c = inc_r[WIDTH];
                v = add_ovf(A[WIDTH-1], 1'b0, inc_r[WIDTH-1]);
            end
            OP_DEC: begin
                D = dec_r[WIDTH-1:0];
                c = dec_r[WIDTH];
                v = sub_ovf(A[WIDTH-1], 1'b0, dec_r[WIDTH-1]);
            end
            OP_PASSB: D = B;
            OP_CMP: begin
                D = A;
                c = cmp_r[WIDTH];
                v = sub_ovf(A[WIDTH-1], B[WIDTH-1], cmp_r[WIDTH-1]);
            end
            default: D = '0;
        endcase
    end

    assign nz_src = (F == OP_CMP) ? cmp_r[WIDTH-1:0] : D;

    // Assemble {C,V,N,Z}.
    always_comb begin
        flags        = '0;
        flags[FLG_C] = c;
        flags[FLG_V] = v;
        flags[FLG_N] = nz_src[WIDTH-1];
        flags[FLG_Z] = (nz_src == '0);
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential ALU with valid/ready handshake and shift-add multiplier
import alu_pkg::*;

module alu_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic [3:0]       F,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] D_hi,
    output logic [3:0]       flags
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [0:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;

    logic               accept;
    logic               mul_go;
    logic               mul_done;
    logic [WIDTH-1:0]   core_d;
    logic [3:0]         core_flags;
    logic [3:0]         mul_flags;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .F     (F),
        .D     (core_d),
        .flags (core_flags)
    );

    // A new bundle may enter only when idle and the output slot is free or draining now.
    assign in_ready = !rst && (state == ST_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign mul_go   = accept && (F == OP_MUL);
    assign mul_done = (state == ST_MUL_RUN) && (cnt == CNT_LAST);
    assign acc_nxt  = mplier[0] ? (acc + mcand) : acc;

    // MUL status: carry marks a non-zero high half, Z covers the whole product.
    always_comb begin
        mul_flags        = '0;
        mul_flags[FLG_C] = |acc_nxt[2*WIDTH-1:WIDTH];
        mul_flags[FLG_Z] = (acc_nxt == '0);
    end

    // Multiply FSM and shift-add datapath; one partial product per clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (state == ST_IDLE) begin
            if (mul_go) begin
                state  <= ST_MUL_RUN;
                cnt    <= '0;
                mcand  <= {{WIDTH{1'b0}}, A};
                mplier <= B;
                acc    <= '0;
            end
        end else begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (mul_done) begin
                state <= ST_IDLE;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Output register: load on a single-cycle accept or MUL completion, else drain on out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            D         <= '0;
            D_hi      <= '0;
            flags     <= '0;
        end else if (accept && !mul_go) begin
            out_valid <= 1'b1;
            D         <= core_d;
            D_hi      <= '0;
            flags     <= core_flags;
        end else if (mul_done) begin
            out_valid <= 1'b1;
            D         <= acc_nxt[WIDTH-1:0];
            D_hi      <= acc_nxt[2*WIDTH-1:WIDTH];
            flags     <= mul_flags;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard testbench for alu_seq
import alu_pkg::*;

module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, Cin, out_valid, out_ready;
    logic [3:0] A, B, F, D, D_hi, flags;

    logic       in_valid8, in_ready8, Cin8, out_valid8, out_ready8;
    logic [7:0] A8, B8, D8, D_hi8;
    logic [3:0] F8, flags8;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_pops = 0;
    int pop_cyc [0:127];
    logic [11:0] exp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    alu_seq #(.WIDTH(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Cin(Cin), .F(F), .out_valid(out_valid), .out_ready(out_ready),
        .D(D), .D_hi(D_hi), .flags(flags)
    );

    alu_seq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .A(A8), .B(B8), .Cin(Cin8), .F(F8), .out_valid(out_valid8), .out_ready(out_ready8),
        .D(D8), .D_hi(D_hi8), .flags(flags8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference for WIDTH=4 using plain integer arithmetic; returns {D_hi, D, C, V, N, Z}.
    function automatic logic [11:0] model(input int a, input int b, input int cin, input int f);
        int r, sa, sb, sr, d, hi;
        logic c, v, n, z;
        sa = (a > 7) ? a - 16 : a;
        sb = (b > 7) ? b - 16 : b;
        r = 0; sr = 0; d = 0; hi = 0; c = 1'b0; v = 1'b0;
        case (f)
            0:  begin r = a + b + cin; sr = sa + sb + cin; c = (r > 15); v = (sr > 7) || (sr < -8); d = r & 15; end
            1:  begin r = a - b - cin; sr = sa - sb - cin; c = (r < 0);  v = (sr > 7) || (sr < -8); d = r & 15; end
            2:  d = a & b;
            3:  d = a | b;
            4:  d = a ^ b;
            5:  d = (~a) & 15;
            6:  d = (~(a & b)) & 15;
            7:  d = (~(a | b)) & 15;
            8:  begin d = ((a << 1) | cin) & 15; c = (a > 7); end
            9:  begin d = a >> 1; c = ((a & 1) != 0); end
            10: begin d = (a >> 1) | (a & 8); c = ((a & 1) != 0); end
            11: begin r = a + 1; sr = sa + 1; c = (r > 15); v = (sr > 7); d = r & 15; end
            12: begin r = a - 1; sr = sa - 1; c = (r < 0); v = (sr < -8); d = r & 15; end
            13: d = b;
            14: begin r = a * b; d = r & 15; hi = r >> 4; c = (hi != 0); end
            default: begin r = a - b; sr = sa - sb; c = (r < 0); v = (sr > 7) || (sr < -8); d = a; end
        endcase
        n = (d > 7);
        z = (d == 0);
        if (f == 14) begin n = 1'b0; z = (r == 0); end
        if (f == 15) begin n = ((r & 15) > 7); z = ((r & 15) == 0); end
        return {4'(hi), 4'(d), c, v, n, z};
    endfunction

    // Scoreboard: compare every consumed result against the oldest expectation.
    always @(negedge clk) begin
        logic [11:0] e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("res_d", 32'(D), 32'(e[7:4]));
                check("res_hi", 32'(D_hi), 32'(e[11:8]));
                check("res_flags", 32'(flags), 32'(e[3:0]));
                if (n_pops < 128) pop_cyc[n_pops] = cyc;
                n_pops++;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the acceptance edge.
    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic cin,
                        input logic [3:0] f, input logic [11:0] exp);
        int k;
        A = a; B = b; Cin = cin; F = f; in_valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
        else exp_q.push_back(exp);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("drain", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        int pb;
        logic [3:0] ra, rb;
        logic       rc;

        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0; F = '0; out_ready = 1'b1;
        in_valid8 = 1'b0; A8 = '0; B8 = '0; Cin8 = 1'b0; F8 = '0; out_ready8 = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_d", 32'(D), 32'd0);
        check("rst_d_hi", 32'(D_hi), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // 1: ADD with carry, ADD overflow, single-cycle latency
        send(4'd7, 4'd9, 1'b1, OP_ADD, {4'd0, 4'd1, 4'b1000});
        @(negedge clk);
        check("add_latency", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        send(4'd7, 4'd1, 1'b0, OP_ADD, {4'd0, 4'd8, 4'b0110});
        // 2: SUB borrow, CMP equal
        send(4'd0, 4'd1, 1'b0, OP_SUB, {4'd0, 4'd15, 4'b1010});
        send(4'd5, 4'd5, 1'b1, OP_CMP, {4'd0, 4'd5, 4'b0001});
        drain();

        // 3: MUL 15*15, latency WIDTH+1, in_ready low while running
        send(4'd15, 4'd15, 1'b0, OP_MUL, {4'd14, 4'd1, 4'b1000});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mul_busy_valid", 32'(out_valid), 32'd0);
            check("mul_busy_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        check("mul_latency", 32'(out_valid), 32'd1);
        drain();

        // 3b: WIDTH=8 multiply 200*3
        in_valid8 = 1'b1; A8 = 8'd200; B8 = 8'd3; F8 = OP_MUL;
        @(negedge clk);
        check("mul8_in_ready", 32'(in_ready8), 32'd1);
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        k = 0;
        @(negedge clk);
        while (!out_valid8 && k < 30) begin
            @(negedge clk);
            k++;
        end
        check("mul8_latency", 32'(k), 32'd8);
        check("mul8_d", 32'(D8), 32'h58);
        check("mul8_d_hi", 32'(D_hi8), 32'd2);
        check("mul8_flags", 32'(flags8), 32'b1000);
        @(posedge clk);
        #1;

        // 4: backpressure holds the result and blocks the next bundle
        out_ready = 1'b0;
        send(4'd3, 4'd4, 1'b0, OP_ADD, {4'd0, 4'd7, 4'b0000});
        A = 4'd1; B = 4'd1; Cin = 1'b0; F = OP_ADD; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_d", 32'(D), 32'd7);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(4'd1, 4'd1, 1'b0, OP_ADD, {4'd0, 4'd2, 4'b0000});
        @(negedge clk);
        check("bp_second_latency", 32'(out_valid), 32'd1);
        drain();

        // 5: back-to-back stream of opcodes 0..12 with random operands
        pb = n_pops;
        for (int f = 0; f < 13; f++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rc = 1'($urandom_range(0, 1));
            send(ra, rb, rc, 4'(f), model(int'(ra), int'(rb), int'(rc), f));
        end
        drain();
        check("stream_count", 32'(n_pops - pb), 32'd13);
        if (n_pops - pb == 13) check("stream_rate", 32'(pop_cyc[pb + 12] - pop_cyc[pb]), 32'd12);

        // 6: reset mid-multiply discards everything
        send(4'd0, 4'd9, 1'b0, OP_PASSB, {4'd0, 4'd9, 4'b0010});
        drain();
        send(4'd13, 4'd11, 1'b0, OP_MUL, model(13, 11, 0, 14));
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_d", 32'(D), 32'd0);
        check("midrst_d_hi", 32'(D_hi), 32'd0);
        check("midrst_flags", 32'(flags), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        k = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) k++;
        end
        check("midrst_stale", 32'(k), 32'd0);
        @(posedge clk);
        #1;
        send(4'd1, 4'd1, 1'b0, OP_ADD, {4'd0, 4'd2, 4'b0000});
        @(negedge clk);
        check("midrst_add_d", 32'(D), 32'd2);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
